// File: rtl/div8b4_seq_if.sv
// div8b4_seq_if: start/operand/result bundle between a requester and the divider
interface div8b4_seq_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
    modport slave  (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div8b4_seq.sv
// div8b4_seq: 8-by-4 unsigned restoring divider, one quotient bit per clock, MSB first
module div8b4_seq (
    input  logic          clk,
    input  logic          rst,
    div8b4_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state_q, state_d;
    logic [7:0] dvd_q, dvd_d, quo_q, quo_d;
    logic [3:0] dvs_q, dvs_d, rem_q, rem_d;
    logic [4:0] pr_q, pr_d, pr_sh;
    logic [2:0] cnt_q, cnt_d;
    logic       done_q, done_d, dbz_q, dbz_d, ge, zero;
    // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        pr_sh   = {pr_q[3:0], dvd_q[7]};
        ge      = pr_sh >= {1'b0, dvs_q};
        zero    = dvs_q == 4'd0;
        case (state_q)
            IDLE: if (bus.start) begin
                dvd_d   = bus.dividend;
                dvs_d   = bus.divisor;
                pr_d    = '0;
                cnt_d   = '0;
                state_d = bus.divisor == 4'd0 ? DONE : RUN;
            end
            RUN: begin
                pr_d    = ge ? pr_sh - {1'b0, dvs_q} : pr_sh;
                dvd_d   = {dvd_q[6:0], ge};
                cnt_d   = cnt_q + 3'd1;
                state_d = cnt_q == 3'd7 ? DONE : RUN;
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                quo_d   = zero ? 8'hFF : dvd_q;
                rem_d   = zero ? 4'hF : pr_q[3:0];
                dbz_d   = zero;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end
    assign bus.busy        = state_q != IDLE;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div8b4_seq.sv
// tb_div8b4_seq: directed and random checks of div8b4_seq against a queued reference
module tb_div8b4_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div8b4_seq_if bus();
    div8b4_seq dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct packed {logic [7:0] q; logic [3:0] r; logic z;} exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;
    logic [7:0] last_q = '0;
    logic [3:0] last_r = '0;
    logic       last_z = 1'b0;
    logic       prev_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        check("done_pulse", {31'd0, prev_done & bus.done}, 32'd0);
        if (bus.done) begin
            if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", {24'd0, bus.quotient}, {24'd0, e.q});
                check("remainder", {28'd0, bus.remainder}, {28'd0, e.r});
                check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.z});
            end
        end
        prev_done = bus.done;
    end

    task automatic go(input logic [7:0] a, input logic [3:0] b, input bit disturb);
        exp_t e;
        int n;
        bit seen;
        e.z = b == 4'd0;
        e.q = e.z ? 8'hFF : 8'(a / {4'd0, b});
        e.r = e.z ? 4'hF : 4'(a % {4'd0, b});
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            check("hold_q", {24'd0, bus.quotient}, {24'd0, last_q});
            check("hold_r", {28'd0, bus.remainder}, {28'd0, last_r});
            if (disturb && n == 3) begin
                bus.start = 1'b1;
                bus.dividend = 8'd50;
                bus.divisor = 4'd5;
            end
            if (disturb && n == 4) begin
                bus.start = 1'b0;
                bus.dividend = 8'd200;
            end
            @(posedge clk);
            #1;
            n++;
            seen = bus.done;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("latency", n, e.z ? 32'd1 : 32'd9);
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
        last_q = e.q;
        last_r = e.r;
        last_z = e.z;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_q", {24'd0, bus.quotient}, 32'd0);
        check("rst_r", {28'd0, bus.remainder}, 32'd0);
        check("rst_z", {31'd0, bus.div_by_zero}, 32'd0);
        go(8'd100, 4'd7, 1'b0);
        go(8'd255, 4'd1, 1'b0);
        go(8'd200, 4'd15, 1'b0);
        go(8'd5, 4'd9, 1'b0);
        go(8'd0, 4'd3, 1'b0);
        go(8'd77, 4'd0, 1'b0);
        go(8'd100, 4'd7, 1'b1);
        repeat (15) @(posedge clk);
        #1;
        check("hold_after_ignored_start_q", {24'd0, bus.quotient}, 32'd14);
        check("hold_after_ignored_start_r", {28'd0, bus.remainder}, 32'd2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor = 4'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_q", {24'd0, bus.quotient}, 32'd0);
        check("abort_r", {28'd0, bus.remainder}, 32'd0);
        check("abort_z", {31'd0, bus.div_by_zero}, 32'd0);
        last_q = '0;
        last_r = '0;
        last_z = 1'b0;
        repeat (12) @(posedge clk);
        go(8'd9, 4'd3, 1'b0);
        for (int i = 0; i < 8; i++)
            go(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
